// File: rtl/display_scanner_if.sv
// Host-side bundle for the display scanner: digit data and controls in, scan state out.
// The scanner attaches via the slave modport; the producer of digit data uses master.
interface display_scanner_if;
  logic [31:0] digits_in;
  logic        load;
  logic [7:0]  digit_en;
  logic        lz_blank;
  logic [3:0]  v;
  logic [2:0]  anum;
  logic        blank;
  logic        frame_tick;
  logic        pending;

  modport master (
    output digits_in, load, digit_en, lz_blank,
    input  v, anum, blank, frame_tick, pending
  );

  modport slave (
    input  digits_in, load, digit_en, lz_blank,
    output v, anum, blank, frame_tick, pending
  );
endinterface

// File: rtl/display_scanner.sv
// Time-multiplexed 8-digit BCD scanner with a double-buffered value that only swaps at frame
// boundaries, plus per-digit enable, invalid-code blanking and leading-zero suppression.
module display_scanner #(
  parameter int unsigned REFRESH_DIV = 100000
) (
  input logic               clk,
  input logic               rst,
  display_scanner_if.slave  bus
);

  localparam int unsigned CntW = $clog2(REFRESH_DIV);
  localparam logic [CntW-1:0] PrescMax = CntW'(REFRESH_DIV - 1);

  logic [CntW-1:0] presc_q, presc_d;
  logic [2:0]      anum_q, anum_d;
  logic [31:0]     active_q, active_d;
  logic [31:0]     shadow_q, shadow_d;
  logic            pending_q, pending_d;
  logic            frame_tick_q, frame_tick_d;

  logic            step;
  logic            frame_edge;
  logic [3:0]      v_cur;
  logic [7:0]      zero_from;
  logic            blank_cur;

  always_comb begin
    step       = (presc_q == PrescMax);
    frame_edge = step && (anum_q == 3'd7);

    presc_d      = step ? '0 : presc_q + 1'b1;
    anum_d       = step ? anum_q + 3'd1 : anum_q;
    frame_tick_d = frame_edge;

    active_d  = active_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    if (bus.load) begin
      if (frame_edge) begin
        // Straight to the display; any older shadow is stale and dropped with pending.
        active_d  = bus.digits_in;
        pending_d = 1'b0;
      end else begin
        shadow_d  = bus.digits_in;
        pending_d = 1'b1;
      end
    end else if (frame_edge && pending_q) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q      <= '0;
      anum_q       <= '0;
      active_q     <= '0;
      shadow_q     <= '0;
      pending_q    <= 1'b0;
      frame_tick_q <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      anum_q       <= anum_d;
      active_q     <= active_d;
      shadow_q     <= shadow_d;
      pending_q    <= pending_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  // zero_from[k] is set when nibbles k..7 of the active value are all zero.
  always_comb begin
    logic run;
    run       = 1'b1;
    zero_from = '0;
    for (int k = 7; k >= 0; k--) begin
      run          = run && (active_q[4*k +: 4] == 4'd0);
      zero_from[k] = run;
    end
  end

  always_comb begin
    v_cur     = active_q[{anum_q, 2'b00} +: 4];
    blank_cur = !bus.digit_en[anum_q]
             || (v_cur > 4'd9)
             || (bus.lz_blank && (anum_q != 3'd0) && zero_from[anum_q]);
  end

  assign bus.v          = v_cur;
  assign bus.anum       = anum_q;
  assign bus.blank      = blank_cur;
  assign bus.frame_tick = frame_tick_q;
  assign bus.pending    = pending_q;

endmodule

// File: tb/tb_display_scanner.sv
// Directed bench for display_scanner with REFRESH_DIV = 4: scan timing, double buffering,
// blanking rules and asynchronous reset, against hand-computed expectations.
module tb_display_scanner;

  logic clk;
  logic rst;
  int unsigned n_cmp;
  int unsigned n_bad;
  int unsigned edges;

  display_scanner_if bus ();

  display_scanner #(
    .REFRESH_DIV (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (edges=%0d)", tag, obs, exp, edges);
    end
  endtask

  // One clock, then sample 1 time unit after the rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
    edges++;
  endtask

  // Advance to the given position within the 32-edge frame (bounded to one frame).
  task automatic run_to(input int unsigned m);
    for (int i = 0; i < 32; i++) begin
      if (edges % 32 == m) break;
      cyc();
    end
  endtask

  task automatic check_frame(input string tag, input logic [31:0] val, input logic [7:0] exp_blank);
    run_to(0);
    check_eq({tag, "_tick"}, 32'(bus.frame_tick), 32'd1);
    for (int k = 0; k < 8; k++) begin
      run_to(32'(4 * k + 1));
      check_eq({tag, "_anum"}, 32'(bus.anum), 32'(k));
      check_eq({tag, "_v"}, 32'(bus.v), 32'(val[4*k +: 4]));
      check_eq({tag, "_blank"}, 32'(bus.blank), 32'(exp_blank[k]));
      check_eq({tag, "_pend"}, 32'(bus.pending), 32'd0);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    edges = 0;
    rst = 1'b1;
    bus.load = 1'b0;
    bus.digits_in = '0;
    bus.digit_en = 8'hFF;
    bus.lz_blank = 1'b0;

    // Reset state, and load ignored during reset.
    repeat (2) @(posedge clk);
    #1;
    bus.digits_in = 32'hDEADBEEF;
    bus.load = 1'b1;
    @(posedge clk);
    #1;
    bus.load = 1'b0;
    check_eq("rst_v", 32'(bus.v), 32'd0);
    check_eq("rst_anum", 32'(bus.anum), 32'd0);
    check_eq("rst_pend", 32'(bus.pending), 32'd0);
    check_eq("rst_tick", 32'(bus.frame_tick), 32'd0);
    check_eq("rst_blank_en", 32'(bus.blank), 32'd0);
    bus.digit_en = 8'hFE;
    #1;
    check_eq("rst_blank_dis", 32'(bus.blank), 32'd1);
    bus.digit_en = 8'hFF;
    rst = 1'b0;
    edges = 0;

    // Free run: anum steps every 4 edges, one frame_tick per 32 edges at anum 0.
    for (int e = 1; e <= 64; e++) begin
      cyc();
      check_eq("run_anum", 32'(bus.anum), 32'((e / 4) % 8));
      check_eq("run_tick", 32'(bus.frame_tick), 32'(e % 32 == 0));
    end
    check_eq("run_v", 32'(bus.v), 32'd0);

    // Mid-frame load held off until the frame boundary.
    run_to(10);
    bus.digits_in = 32'h87654321;
    bus.load = 1'b1;
    cyc();
    bus.load = 1'b0;
    check_eq("mid_pend", 32'(bus.pending), 32'd1);
    check_eq("mid_v_old", 32'(bus.v), 32'd0);
    run_to(28);
    check_eq("mid_anum7", 32'(bus.anum), 32'd7);
    check_eq("mid_v_old7", 32'(bus.v), 32'd0);
    check_eq("mid_pend7", 32'(bus.pending), 32'd1);
    check_frame("mid", 32'h87654321, 8'h00);

    // Two loads in one frame: last wins, leading zeros blanked.
    run_to(5);
    bus.digits_in = 32'h00000000;
    bus.load = 1'b1;
    cyc();
    bus.digits_in = 32'h00001234;
    cyc();
    bus.load = 1'b0;
    bus.lz_blank = 1'b1;
    check_eq("two_pend", 32'(bus.pending), 32'd1);
    check_eq("two_v_old", 32'(bus.v), 32'd2);
    run_to(28);
    check_eq("two_v_old7", 32'(bus.v), 32'd8);
    check_eq("two_blank_old7", 32'(bus.blank), 32'd0);
    check_frame("two", 32'h00001234, 8'hF0);

    // Load on the boundary cycle bypasses the shadow and discards an older pending value.
    run_to(20);
    bus.digits_in = 32'h11111111;
    bus.load = 1'b1;
    cyc();
    bus.load = 1'b0;
    check_eq("bnd_pend_old", 32'(bus.pending), 32'd1);
    run_to(31);
    check_eq("bnd_anum7", 32'(bus.anum), 32'd7);
    bus.digits_in = 32'h00005678;
    bus.load = 1'b1;
    cyc();
    bus.load = 1'b0;
    check_eq("bnd_v0", 32'(bus.v), 32'd8);
    check_eq("bnd_pend", 32'(bus.pending), 32'd0);
    check_frame("bnd", 32'h00005678, 8'hF0);

    // A zero value shows a single 0 on digit 0.
    run_to(10);
    bus.digits_in = 32'h00000000;
    bus.load = 1'b1;
    cyc();
    bus.load = 1'b0;
    check_frame("zero", 32'h00000000, 8'hFE);

    // Invalid code on digit 2 and digit 0 disabled.
    bus.lz_blank = 1'b0;
    bus.digit_en = 8'hFE;
    run_to(10);
    bus.digits_in = 32'h12345A78;
    bus.load = 1'b1;
    cyc();
    bus.load = 1'b0;
    check_frame("inv", 32'h12345A78, 8'h05);
    bus.digit_en = 8'hFF;

    // One-cycle reset mid-frame with a pending value.
    run_to(10);
    bus.digits_in = 32'h99999999;
    bus.load = 1'b1;
    cyc();
    bus.load = 1'b0;
    check_eq("ar_pend_pre", 32'(bus.pending), 32'd1);
    run_to(14);
    rst = 1'b1;
    #2;
    check_eq("ar_anum", 32'(bus.anum), 32'd0);
    check_eq("ar_pend", 32'(bus.pending), 32'd0);
    check_eq("ar_v", 32'(bus.v), 32'd0);
    check_eq("ar_tick", 32'(bus.frame_tick), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    edges = 0;
    repeat (3) cyc();
    check_eq("ar_hold3", 32'(bus.anum), 32'd0);
    cyc();
    check_eq("ar_step4", 32'(bus.anum), 32'd1);
    run_to(0);
    check_eq("ar_tick32", 32'(bus.frame_tick), 32'd1);
    run_to(1);
    check_eq("ar_v_after", 32'(bus.v), 32'd0);
    check_eq("ar_pend_after", 32'(bus.pending), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
